// File: rtl/ball_platform_drawer.sv
// Pixel writer for the colour-bounce game.
// Erases the old ball, draws the new ball, then repaints all platforms.
module ball_platform_drawer #(
  parameter int          BALL_X    = 76,
  parameter int          BALL_SZ   = 4,
  parameter int          PLAT_X    = 72,
  parameter int          PLAT_W    = 16,
  parameter int          SCREEN_H  = 160,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  prev_ball,
  input  logic [7:0]  curr_ball,
  input  logic [31:0] position_plats,
  input  logic [11:0] color_plats,
  input  logic [2:0]  color_ball,
  output logic        busy,
  output logic        done,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot
);

  localparam int CW =
    ($clog2(PLAT_W) > 4) ? $clog2(PLAT_W) : 4;
  localparam logic [CW-1:0] BALL_LAST =
    CW'(BALL_SZ * BALL_SZ - 1);
  localparam logic [CW-1:0] PLAT_LAST =
    CW'(PLAT_W - 1);

  typedef enum logic [2:0] {
    IDLE, ERASE, BALL, PLAT, FIN
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    prev_q, prev_d;
  logic [7:0]    curr_q, curr_d;
  logic [31:0]   pos_q, pos_d;
  logic [11:0]   cplat_q, cplat_d;
  logic [2:0]    cball_q, cball_d;
  logic [CW-1:0] pix_q, pix_d;
  logic [1:0]    pl_q, pl_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic          pix_wrap;
  logic [7:0]    base;
  logic [7:0]    row;
  logic [2:0]    pcol;
  logic [8:0]    ys9;

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // State and datapath registers; reset abandons any frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      curr_q   <= '0;
      pos_q    <= '0;
      cplat_q  <= '0;
      cball_q  <= '0;
      pix_q    <= '0;
      pl_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      curr_q   <= curr_d;
      pos_q    <= pos_d;
      cplat_q  <= cplat_d;
      cball_q  <= cball_d;
      pix_q    <= pix_d;
      pl_q     <= pl_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Phase sequencing; FIN may chain straight into a new frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ERASE;
      ERASE: if (pix_q == BALL_LAST) state_d = BALL;
      BALL:  if (pix_q == BALL_LAST) state_d = PLAT;
      PLAT:  if (pix_q == PLAT_LAST && pl_q == 2'd3)
               state_d = FIN;
      FIN:   state_d = start ? ERASE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel generation, counters, status and input capture.
  always_comb begin
    prev_d   = prev_q;
    curr_d   = curr_q;
    pos_d    = pos_q;
    cplat_d  = cplat_q;
    cball_d  = cball_q;
    pix_d    = pix_q;
    pl_d     = pl_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    base     = prev_q;
    row      = pos_q[7:0];
    pcol     = cplat_q[2:0];
    ys9      = '0;
    pix_wrap = 1'b0;
    accept   = start &&
               (state_q == IDLE || state_q == FIN);

    unique case (state_q)
      IDLE: busy_d = start;
      ERASE, BALL: begin
        base     = (state_q == ERASE) ? prev_q : curr_q;
        ys9      = {1'b0, base} + {7'b0, pix_q[3:2]};
        x_d      = 8'(BALL_X) + {6'b0, pix_q[1:0]};
        y_d      = ys9[7:0];
        colour_d = (state_q == ERASE) ? BG_COLOUR
                                      : cball_q;
        plot_d   = ys9 < 9'(SCREEN_H);
        pix_wrap = pix_q == BALL_LAST;
        pix_d    = pix_wrap ? '0 : pix_q + CW'(1);
        busy_d   = 1'b1;
      end
      PLAT: begin
        unique case (pl_q)
          2'd0: begin
            row  = pos_q[7:0];
            pcol = cplat_q[2:0];
          end
          2'd1: begin
            row  = pos_q[15:8];
            pcol = cplat_q[5:3];
          end
          2'd2: begin
            row  = pos_q[23:16];
            pcol = cplat_q[8:6];
          end
          default: begin
            row  = pos_q[31:24];
            pcol = cplat_q[11:9];
          end
        endcase
        ys9      = {1'b0, row};
        x_d      = 8'(PLAT_X) + 8'(pix_q);
        y_d      = row;
        colour_d = pcol;
        plot_d   = ys9 < 9'(SCREEN_H);
        pix_wrap = pix_q == PLAT_LAST;
        pix_d    = pix_wrap ? '0 : pix_q + CW'(1);
        pl_d     = pix_wrap ? pl_q + 2'd1 : pl_q;
        busy_d   = 1'b1;
      end
      FIN: begin
        done_d = 1'b1;
        busy_d = start;
      end
      default: busy_d = 1'b0;
    endcase

    if (accept) begin
      prev_d  = prev_ball;
      curr_d  = curr_ball;
      pos_d   = position_plats;
      cplat_d = color_plats;
      cball_d = color_ball;
      pix_d   = '0;
      pl_d    = '0;
    end
  end

endmodule

// File: tb/tb_ball_platform_drawer.sv
// Directed bench for ball_platform_drawer.
// Frames are checked pixel by pixel against a small reference model.
module tb_ball_platform_drawer;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  prev_ball = '0;
  logic [7:0]  curr_ball = '0;
  logic [31:0] position_plats = '0;
  logic [11:0] color_plats = '0;
  logic [2:0]  color_ball = '0;
  logic        busy, done, plot;
  logic [7:0]  x, y;
  logic [2:0]  colour;

  int total = 0;
  int bad = 0;

  logic [7:0]  m_prev, m_curr;
  logic [31:0] m_pos;
  logic [11:0] m_cp;
  logic [2:0]  m_cb;
  logic [19:0] cap [96];

  ball_platform_drawer dut (
    .clk(clk), .resetn(resetn), .start(start),
    .prev_ball(prev_ball), .curr_ball(curr_ball),
    .position_plats(position_plats),
    .color_plats(color_plats),
    .color_ball(color_ball),
    .busy(busy), .done(done),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // {plot, x, y, colour} expected for pixel n
  function automatic logic [19:0] expp(int n);
    int k, dx, dy, i, s, xx;
    logic [2:0] c;
    if (n < 32) begin
      k  = n % 16;
      dx = k % 4;
      dy = k / 4;
      xx = 76 + dx;
      s  = ((n < 16) ? int'(m_prev) : int'(m_curr)) + dy;
      c  = (n < 16) ? 3'd0 : m_cb;
    end else begin
      k  = n - 32;
      i  = k / 16;
      dx = k % 16;
      xx = 72 + dx;
      s  = int'(m_pos[8*i +: 8]);
      c  = m_cp[3*i +: 3];
    end
    return {(s < 160) ? 1'b1 : 1'b0, 8'(xx), 8'(s), c};
  endfunction

  task automatic setup(input logic [7:0] pb,
                       input logic [7:0] cb_row,
                       input logic [2:0] cb,
                       input logic [31:0] pos,
                       input logic [11:0] cp);
    prev_ball = pb;  m_prev = pb;
    curr_ball = cb_row; m_curr = cb_row;
    color_ball = cb; m_cb = cb;
    position_plats = pos; m_pos = pos;
    color_plats = cp; m_cp = cp;
  endtask

  task automatic run_frame(input bit do_start,
                           input bit hold,
                           input int s1,
                           input int s2,
                           input bit mut);
    int plots;
    int eplots;
    logic [19:0] e;
    plots = 0;
    eplots = 0;
    if (do_start) begin
      start = 1'b1;
      tick();
      chk("e0_status", {done, busy, plot}, 3'b010);
      if (mut) begin
        curr_ball = 8'd50;
        color_ball = 3'd2;
      end
    end
    if (!hold) start = 1'b0;
    for (int n = 0; n < 96; n++) begin
      tick();
      e = expp(n);
      eplots += int'(e[19]);
      chk($sformatf("pix%0d", n),
          {done, busy, plot, x, y, colour},
          {2'b01, e});
      cap[n] = {plot, x, y, colour};
      plots += int'(plot);
      if (n == s1 || n == s2) start = 1'b1;
      else if (!hold) start = 1'b0;
    end
    tick();
    chk("fin_done_plot", {done, plot}, 2'b10);
    chk("plot_count", plots, eplots);
    if (!hold) begin
      chk("fin_busy", busy, 1'b0);
      tick();
      chk("idle_after", {done, busy, plot}, 3'b000);
    end
  endtask

  initial begin
    #1 resetn = 1'b0;
    tick();
    tick();
    chk("rst_out", {busy, done, plot, x, y, colour}, '0);
    resetn = 1'b1;
    tick();
    chk("idle_out", {busy, done, plot}, 3'b000);

    // Basic frame, inputs disturbed after E0
    setup(8'd10, 8'd11, 3'b101, 32'h28_50_78_96,
          12'b001010100111);
    run_frame(1, 0, -1, -1, 1);
    chk("b_p0",  cap[0],  {1'b1, 8'd76, 8'd10, 3'd0});
    chk("b_p15", cap[15], {1'b1, 8'd79, 8'd13, 3'd0});
    chk("b_p16", cap[16], {1'b1, 8'd76, 8'd11, 3'd5});
    chk("b_p31", cap[31], {1'b1, 8'd79, 8'd14, 3'd5});
    chk("b_p32", cap[32], {1'b1, 8'd72, 8'h96, 3'd7});
    chk("b_p95", cap[95], {1'b1, 8'd87, 8'h28, 3'd1});

    // Bottom clipping of the ball
    setup(8'd0, 8'd158, 3'b011, 32'h10_20_30_40,
          12'b110101011100);
    run_frame(1, 0, -1, -1, 0);
    chk("c_p19", cap[19], {1'b1, 8'd79, 8'd158, 3'd3});
    chk("c_p20", cap[20], {1'b1, 8'd76, 8'd159, 3'd3});
    chk("c_p24", cap[24], {1'b0, 8'd76, 8'd160, 3'd3});
    chk("c_p29", cap[29], {1'b0, 8'd77, 8'd161, 3'd3});

    // Start while busy is ignored
    setup(8'd40, 8'd42, 3'b110, 32'h01_02_03_04,
          12'b011011011011);
    run_frame(1, 0, 5, 50, 0);

    // Back-to-back frames with start held high
    setup(8'd90, 8'd93, 3'b001, 32'h9F_00_55_AA,
          12'b111000101010);
    run_frame(1, 1, -1, -1, 0);
    run_frame(0, 1, -1, -1, 0);
    run_frame(0, 0, -1, -1, 0);

    // Reset at pixel 20
    setup(8'd20, 8'd24, 3'b010, 32'h05_06_07_08,
          12'b100100100100);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    chk("mid_pix20", {plot, x, y},
        {1'b1, 8'd76, 8'd25});
    resetn = 1'b0;
    #1;
    chk("mid_rst", {busy, done, plot, x, y, colour}, '0);
    tick();
    tick();
    chk("mid_hold", {busy, done, plot}, 3'b000);
    resetn = 1'b1;
    tick();
    run_frame(1, 0, -1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
